// File: rtl/addsub_pkg.sv
// Shared constants for the bit-serial add/subtract sequencer: operation codes
// and FSM state encodings.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// Full adder built from two half adders, with an OR merging their carries.
module fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .i_a     (i_a),
        .i_b     (i_b),
        .o_sum   (w_s0),
        .o_carry (w_c0)
    );

    half_adder u_ha1 (
        .i_a     (w_s0),
        .i_b     (i_cin),
        .o_sum   (o_sum),
        .o_carry (w_c1)
    );

    // The two half-adder carries can never both be 1, so OR suffices.
    assign o_cout = w_c0 | w_c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder, the base datapath cell.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract: one full-adder cell walks WIDTH-bit operands LSB
// first, one bit per clock, behind a start/busy/done handshake.
module serial_addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry_out,
    output logic             o_overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(WIDTH - 2);

    state_t           r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_op;
    logic             r_c_msb_in;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;

    logic w_sum;
    logic w_cout;

    fa_cell u_fa (
        .i_a    (r_sh_a[0]),
        .i_b    (r_sh_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_op        <= OP_ADD;
            r_c_msb_in  <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        // Subtract as a + ~b + 1: the +1 rides in on the initial carry.
                        r_sh_a  <= i_a;
                        r_sh_b  <= (i_op == OP_SUB) ? ~i_b : i_b;
                        r_carry <= i_op;
                        r_cnt   <= '0;
                        r_op    <= i_op;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == CNT_PRE)
                        r_c_msb_in <= w_cout;
                    if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_result    <= {w_sum, r_res[WIDTH-1:1]};
                        // Raw carry of a + ~b + 1 is the inverse of the borrow.
                        r_carry_out <= (r_op == OP_SUB) ? ~w_cout : w_cout;
                        r_overflow  <= r_c_msb_in ^ w_cout;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state == ST_RUN);
    assign o_done      = (r_state == ST_DONE);
    assign o_result    = r_result;
    assign o_carry_out = r_carry_out;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_serial_addsub_seq.sv
// Scoreboard bench for serial_addsub_seq: expectations are queued at start
// and compared whenever done pulses.
module tb_serial_addsub_seq;

    localparam int WIDTH = 8;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_start;
    logic             i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_carry_out;
    logic             o_overflow;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             ov;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_push = 0;
    int   n_done = 0;
    int   cyc = 0;
    int   last_done_cyc = -1;
    logic prev_done = 1'b0;
    bit   chk_gap = 1'b0;

    serial_addsub_seq #(.WIDTH(WIDTH)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_op        (i_op),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_carry_out (o_carry_out),
        .o_overflow  (o_overflow)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] w;
        exp_t e;
        if (!op) begin
            w    = {1'b0, a} + {1'b0, b};
            e.co = w[WIDTH];
            e.ov = (a[WIDTH-1] == b[WIDTH-1]) && (w[WIDTH-1] != a[WIDTH-1]);
        end else begin
            w    = {1'b0, a} - {1'b0, b};
            e.co = (a < b);
            e.ov = (a[WIDTH-1] != b[WIDTH-1]) && (w[WIDTH-1] != a[WIDTH-1]);
        end
        e.res = w[WIDTH-1:0];
        return e;
    endfunction

    task automatic push(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        sb_q.push_back(model(op, a, b));
        n_push++;
    endtask

    // Scoreboard side: every done pulse consumes one expectation.
    always @(negedge i_clk) begin
        exp_t e;
        if (o_done) begin
            n_done++;
            chk("done_twice", prev_done, 0);
            if (chk_gap && last_done_cyc >= 0) chk("done_gap", cyc - last_done_cyc, WIDTH + 2);
            last_done_cyc = cyc;
            if (sb_q.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("result", o_result, e.res);
                chk("carry_out", o_carry_out, e.co);
                chk("overflow", o_overflow, e.ov);
            end
        end
        prev_done = o_done;
    end

    // Called #1 after a posedge with the DUT idle; returns likewise.
    task automatic do_op(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit poke);
        i_start = 1'b1; i_op = op; i_a = a; i_b = b;
        push(op, a, b);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_a = WIDTH'($urandom); i_b = WIDTH'($urandom); i_op = 1'($urandom);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge i_clk);
            chk("busy_run", o_busy, 1);
            chk("done_early", o_done, 0);
            if (poke && k == 2) begin
                i_start = 1'b1; i_a = 8'hAA; i_b = 8'h55; i_op = 1'b1;
            end
        end
        @(negedge i_clk);
        chk("busy_in_done", o_busy, 0);
        chk("done_pulse", o_done, 1);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(negedge i_clk);
        chk("idle_busy", o_busy, 0);
        @(posedge i_clk); #1;
    endtask

    logic       t_op[10];
    logic [7:0] t_a[10];
    logic [7:0] t_b[10];

    initial begin
        t_op = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1};
        t_a  = '{8'h3C, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h20, 8'h00, 8'h00, 8'h80, 8'h7F};
        t_b  = '{8'h05, 8'h01, 8'h01, 8'h07, 8'h01, 8'h20, 8'h00, 8'hFF, 8'h80, 8'h80};

        i_rst = 1'b1; i_start = 1'b0; i_op = 1'b0; i_a = '0; i_b = '0;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_result", o_result, 0);
        chk("rst_carry", o_carry_out, 0);
        chk("rst_ovf", o_overflow, 0);
        @(posedge i_clk); #1;

        for (int i = 0; i < 10; i++) do_op(t_op[i], t_a[i], t_b[i], 1'b0);
        for (int i = 0; i < 4; i++) do_op(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'b0);

        // Second request and operand changes during RUN must be ignored.
        do_op(1'b0, 8'h10, 8'h01, 1'b1);

        // Reset in the middle of RUN aborts without a done pulse.
        i_start = 1'b1; i_op = 1'b0; i_a = 8'hF0; i_b = 8'h0F;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        chk("abort_result", o_result, 0);
        chk("abort_carry", o_carry_out, 0);
        chk("abort_ovf", o_overflow, 0);
        repeat (WIDTH + 4) begin
            @(negedge i_clk);
            chk("abort_no_done", o_done, 0);
        end
        @(posedge i_clk); #1;
        do_op(1'b0, 8'h01, 8'h01, 1'b0);

        // Start held high: one capture every WIDTH+2 edges.
        chk_gap = 1'b1;
        last_done_cyc = -1;
        i_start = 1'b1; i_op = 1'b0; i_a = 8'h01; i_b = 8'h02;
        repeat (3) push(1'b0, 8'h01, 8'h02);
        repeat (25) @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (14) @(posedge i_clk);
        #1;

        chk("sb_empty", sb_q.size(), 0);
        chk("done_count", n_done, n_push);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_addsub_seq.md
Name: serial_addsub_seq

Overview:
Bit-serial add/subtract sequencer built around the team's half-adder datapath. Two half adders plus an OR form a full-adder cell. This block drives that cell one bit per cycle, LSB first, over WIDTH-bit operands. It owns operand capture, the carry register, bit counting, result assembly and a start/busy/done handshake. It is the first clocked consumer of the half-adder cells and trades area for WIDTH cycles of latency.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse; result/flags valid and updated
result  output  WIDTH  sum or difference, unsigned modulo 2^WIDTH
carry_out  output  1  add: carry out of MSB; sub: borrow (1 when a < b unsigned)
overflow  output  1  two's-complement signed overflow of the last operation

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0; internal shift/count/carry registers cleared. Reset wins over every other input. Reset mid-RUN aborts the operation, and no done is produced.
- States: IDLE, RUN, DONE. Encoding is held in the package.
- IDLE:
  - On an edge with start=1: capture sh_a=a, sh_b = op ? ~b : b, carry=op, cnt=0, op_r=op; go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1):
  - Each edge, the full-adder cell gets sh_a[0], sh_b[0], carry.
  - Sum bit shifts into the result shift register from the MSB side. sh_a and sh_b shift right. carry takes the cell's carry out. cnt increments.
  - On the edge where cnt==WIDTH-2, also save the current carry out as c_msb_in (carry into the MSB).
  - On the edge where cnt==WIDTH-1, go to DONE and update the outputs:
    - result = assembled word
    - carry_out = op_r ? ~cout : cout
    - overflow = c_msb_in XOR cout (cout is the raw cell carry out of the MSB)
- DONE: done=1 for exactly one cycle, busy=0. Next edge goes to IDLE unconditionally. start in DONE is ignored.
- Latency: with start sampled at edge E0, busy is high in the cycles after E0 through edge E(WIDTH). done is high in the cycle after E(WIDTH). Minimum start-to-start spacing is WIDTH+2 edges.
- start while busy or done is ignored, with no queuing. Changes to a, b and op after capture have no effect.
- result, carry_out and overflow hold their values until the next done update. They are not cleared at start.
- Width rules: cnt is clog2(WIDTH) bits wide. The arithmetic is modulo 2^WIDTH, and there is no sign extension.
- Outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package addsub_pkg holds:
  - OP_ADD=1'b0 and OP_SUB=1'b1
  - state encodings ST_IDLE, ST_RUN, ST_DONE (2-bit)
- Sub-module fa_cell: a full adder built from two existing half_adder instances plus an OR for the carry.
  - Ports a, b, cin, sum, cout; purely combinational.
  - Instantiated once in serial_addsub_seq. It is unit-tested separately over all 8 input combinations.

Test Plan:
WIDTH=8 for all scenarios.
1. Reset for 2 cycles, then release -> all outputs 0, busy=0. Add 0x3C+0x05 with start at E0 -> busy high for 8 cycles, done pulse in the cycle after E8; result=0x41, carry_out=0, overflow=0.
2. Add 0xFF+0x01 -> result=0x00, carry_out=1, overflow=0. Add 0x7F+0x01 -> result=0x80, carry_out=0, overflow=1.
3. Sub 0x05-0x07 -> result=0xFE, carry_out(borrow)=1, overflow=0. Sub 0x80-0x01 -> result=0x7F, borrow=0, overflow=1. Sub 0x20-0x20 -> 0x00, borrow=0, overflow=0.
4. Start 0x10+0x01, then pulse start with 0xAA+0x55 and change a/b/op at cycle 3 of RUN -> second request ignored; done fires once, result=0x11; busy never drops early.
5. Start 0xF0+0x0F, assert rst at cycle 4 of RUN -> next cycle busy=0 and outputs are 0; no done pulse follows. A subsequent 0x01+0x01 gives result=0x02.
6. Back-to-back: start held high continuously, operands 0x01+0x02 -> done every 10 cycles (WIDTH+2) and result=0x03 each time; done is never high for two consecutive cycles.
